twofish_ksched_ctrl: RTL

Sequencer for the Twofish subkey-generation datapath (h-function pair generator plus subkey RAM). On start, it latches the key length and steps a 5-bit pair index 0..NUM_PAIRS-1. For each index it launches one h-function evaluation, waits for the datapath result, then writes the K[2i]/K[2i+1] pair into subkey storage. It sits between the top-level key-setup FSM and the key-schedule datapath, replacing free-running counter enables with a handshaked schedule.

---
 rtl/twofish_ksched_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/twofish_ksched_ctrl.sv
// Twofish subkey-generation sequencer: handshaked h-function issue/wait/write per subkey pair.
// Optional WAIT-state timeout enabled by defining KS_TIMEOUT_EN.
module twofish_ksched_ctrl #(
    parameter int NUM_PAIRS   = 20,
    parameter int IDX_W       = 5,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       key_len,
    input  logic             abort,
    input  logic             h_valid,
    output logic             key_load,
    output logic [2:0]       k_words,
    output logic             h_start,
    output logic [IDX_W-1:0] idx,
    output logic             sk_we,
    output logic [IDX_W-1:0] sk_addr,
    output logic             busy,
    output logic             done,
    output logic             err
);

    if (NUM_PAIRS < 2 || NUM_PAIRS > 32 || NUM_PAIRS > (2 ** IDX_W) || TIMEOUT_CYC < 1)
    begin : g_param_check
        $error("twofish_ksched_ctrl: illegal NUM_PAIRS/IDX_W/TIMEOUT_CYC combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAIRS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       kw_q, kw_d;
    logic             err_q, err_d;

`ifdef KS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
`endif

    function automatic logic [2:0] key_words(input logic [1:0] kl);
        case (kl)
            2'b00:   key_words = 3'd2;
            2'b01:   key_words = 3'd3;
            default: key_words = 3'd4;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            kw_q    <= 3'd2;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            kw_q    <= kw_d;
            err_q   <= err_d;
        end
    end

`ifdef KS_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        kw_d    = kw_q;
        err_d   = 1'b0;
`ifdef KS_TIMEOUT_EN
        wcnt_d  = wcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (key_len == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        kw_d    = key_words(key_len);
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                idx_d   = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
`ifdef KS_TIMEOUT_EN
                wcnt_d  = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (h_valid) begin
                    state_d = S_WRITE;
`ifdef KS_TIMEOUT_EN
                // wcnt_q counts completed WAIT cycles; the limit is hit on the last allowed one
                end else if (wcnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d  = wcnt_q + CNT_W'(1);
`endif
                end
            end
            S_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Cancel overrides any datapath handshake or timeout in the same cycle
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            idx_d   = '0;
            err_d   = 1'b0;
        end
    end

    assign key_load = (state_q == S_LOAD);
    assign h_start  = (state_q == S_ISSUE);
    assign sk_we    = (state_q == S_WRITE);
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q != S_IDLE);
    assign idx      = idx_q;
    assign sk_addr  = idx_q;
    assign k_words  = kw_q;
    assign err      = err_q;

endmodule
